// File: rtl/mmio_irq_ctrl.sv
// mmio_irq_ctrl: memory-mapped prioritised interrupt controller.
// It gives N_SRC sources a pending bit, an enable bit and an 8-bit vector each,
// and presents one request at a time to the cpu with an ack/EOI handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request outstanding; cpu may accept interrupts (int_en=1)
// REQ     | request committed to cpu, int_req=1, waiting for int_ack
// SERVICE | cpu is running the handler, waiting for an EOI write
module mmio_irq_ctrl #(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] BASE_ADDR = 8'd240,
    parameter logic [7:0] EDGE_MASK = 8'h01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       addr,
    input  logic [7:0]       w_data,
    input  logic             w_en,
    output logic [7:0]       r_data,
    output logic             r_hit,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             int_ack,
    output logic             int_req,
    output logic [7:0]       int_vec,
    output logic             int_en
);

    localparam int WIN = 4 + N_SRC;

    localparam logic [7:0] OFF_PENDING = 8'd0;
    localparam logic [7:0] OFF_ENABLE  = 8'd1;
    localparam logic [7:0] OFF_ACTIVE  = 8'd2;
    localparam logic [7:0] OFF_EOI     = 8'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       id;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] enable;
    logic [7:0]       vec [N_SRC];

    logic [8:0]       off_wide;
    logic [7:0]       off;
    logic             wr_pending;
    logic             wr_enable;
    logic             wr_eoi;
    logic             ack_clr;
    logic             in_service;

    logic [N_SRC-1:0] req_vec;
    logic             req_any;
    logic [2:0]       sel_id;
    logic [7:0]       sel_vec;

    logic [7:0]       pending_ext;
    logic [7:0]       enable_ext;

    // Window decode: the 9-bit subtract catches addresses below BASE_ADDR via the borrow.
    always_comb begin
        off_wide = {1'b0, addr} - {1'b0, BASE_ADDR};
        off      = off_wide[7:0];
        r_hit    = !off_wide[8] && (off < 8'(WIN));
    end

    // Write strobes and status derived from the bus and the FSM.
    always_comb begin
        wr_pending = w_en && r_hit && (off == OFF_PENDING);
        wr_enable  = w_en && r_hit && (off == OFF_ENABLE);
        wr_eoi     = w_en && r_hit && (off == OFF_EOI);
        ack_clr    = (state == REQ) && int_ack;
        in_service = (state != IDLE);
    end

    // Edge sources latch a rising edge until W1C or ack; level sources mirror the input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            prev    <= '0;
        end else begin
            prev <= irq_src;
            for (int i = 0; i < N_SRC; i++) begin
                if (EDGE_MASK[i]) begin
                    // A new edge beats a simultaneous clear so no event is lost.
                    if (irq_src[i] && !prev[i]) begin
                        pending[i] <= 1'b1;
                    end else if ((wr_pending && w_data[i]) ||
                                 (ack_clr && (id == 3'(i)))) begin
                        pending[i] <= 1'b0;
                    end
                end else begin
                    pending[i] <= irq_src[i];
                end
            end
        end
    end

    // ENABLE mask register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable <= '0;
        end else if (wr_enable) begin
            enable <= w_data[N_SRC-1:0];
        end
    end

    // Per-source vector registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                vec[i] <= '0;
            end
        end else if (w_en && r_hit) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (off == 8'(i + 4)) begin
                    vec[i] <= w_data;
                end
            end
        end
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        req_vec = pending & enable;
        req_any = |req_vec;
        sel_id  = '0;
        sel_vec = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                sel_id  = 3'(i);
                sel_vec = vec[i];
            end
        end
    end

    // Service FSM; int_vec is captured on entry to REQ so later VEC writes cannot disturb it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            id      <= '0;
            int_req <= 1'b0;
            int_vec <= '0;
            int_en  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    int_req <= 1'b0;
                    int_en  <= 1'b1;
                    if (req_any) begin
                        id      <= sel_id;
                        int_vec <= sel_vec;
                        int_req <= 1'b1;
                        int_en  <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req <= 1'b0;
                        state   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        int_en <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    int_req <= 1'b0;
                    int_en  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Zero-extended views of the narrow registers for the read mux.
    always_comb begin
        pending_ext               = '0;
        enable_ext                = '0;
        pending_ext[N_SRC-1:0]    = pending;
        enable_ext[N_SRC-1:0]     = enable;
    end

    // Combinational read mux; EOI and out-of-window addresses read as zero.
    always_comb begin
        r_data = '0;
        if (r_hit) begin
            case (off)
                OFF_PENDING: r_data = pending_ext;
                OFF_ENABLE:  r_data = enable_ext;
                OFF_ACTIVE:  r_data = {in_service, 4'b0000, id};
                default: begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (off == 8'(i + 4)) begin
                            r_data = vec[i];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_irq_ctrl.sv
// Directed bench for mmio_irq_ctrl. Source 2 is configured level-triggered and
// sources 0, 1, 3 edge-triggered so one instance covers every scenario.
module tb_mmio_irq_ctrl;

    logic       clock;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       r_hit;
    logic [3:0] irq_src;
    logic       int_ack;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_en;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] exp_q [$];

    mmio_irq_ctrl #(
        .N_SRC    (4),
        .BASE_ADDR(8'd240),
        .EDGE_MASK(8'h0B)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .addr   (addr),
        .w_data (w_data),
        .w_en   (w_en),
        .r_data (r_data),
        .r_hit  (r_hit),
        .irq_src(irq_src),
        .int_ack(int_ack),
        .int_req(int_req),
        .int_vec(int_vec),
        .int_en (int_en)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        w_data = d;
        w_en   = 1'b1;
        @(negedge clock);
        w_en   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, r_data, exp);
    endtask

    task automatic pulse(input logic [3:0] mask);
        irq_src = irq_src | mask;
        @(negedge clock);
        irq_src = irq_src & ~mask;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        @(negedge clock);
        int_ack = 1'b0;
    endtask

    // Waits a bounded number of cycles for int_req, then checks the vector against the scoreboard.
    task automatic wait_req(input string tag);
        int cnt = 0;
        logic [7:0] exp;
        while (!int_req && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        check({tag, "_req"}, {7'd0, int_req}, 8'h01);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 8'h01, 8'h00);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_vec"}, int_vec, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        addr    = 8'd0;
        w_data  = 8'd0;
        w_en    = 1'b0;
        irq_src = 4'd0;
        int_ack = 1'b0;
        tick(2);
        check("rst_int_req", {7'd0, int_req}, 8'h00);
        check("rst_int_en",  {7'd0, int_en},  8'h01);
        reset = 1'b0;
        tick(1);

        // 1: reset asserted while a request is outstanding
        bus_write(8'd244, 8'h55);
        bus_write(8'd241, 8'h01);
        exp_q.push_back(8'h55);
        pulse(4'b0001);
        wait_req("t1");
        reset = 1'b1;
        #1;
        check("t1_rst_int_req", {7'd0, int_req}, 8'h00);
        check("t1_rst_int_en",  {7'd0, int_en},  8'h01);
        check("t1_rst_int_vec", int_vec, 8'h00);
        for (int a = 240; a < 248; a++) begin
            read_check($sformatf("t1_read_%0d", a), 8'(a), 8'h00);
        end
        @(negedge clock);
        reset = 1'b0;
        tick(1);

        // 2: single edge source with default-ish setup
        bus_write(8'd244, 8'h40);
        bus_write(8'd241, 8'h01);
        exp_q.push_back(8'h40);
        pulse(4'b0001);
        check("t2_req_after_1_edge", {7'd0, int_req}, 8'h00);
        tick(1);
        check("t2_req_after_2_edges", {7'd0, int_req}, 8'h01);
        wait_req("t2");
        check("t2_int_en_req", {7'd0, int_en}, 8'h00);
        read_check("t2_active", 8'd242, 8'h80);
        ack();
        check("t2_ack_int_req", {7'd0, int_req}, 8'h00);
        read_check("t2_pending", 8'd240, 8'h00);
        check("t2_int_en_service", {7'd0, int_en}, 8'h00);
        bus_write(8'd243, 8'h00);
        check("t2_eoi_int_en", {7'd0, int_en}, 8'h01);
        read_check("t2_active_idle", 8'd242, 8'h00);

        // 3: priority between sources 1 and 3
        bus_write(8'd245, 8'h11);
        bus_write(8'd247, 8'h33);
        bus_write(8'd241, 8'h0F);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h33);
        pulse(4'b1010);
        wait_req("t3_first");
        read_check("t3_active_1", 8'd242, 8'h81);
        ack();
        read_check("t3_pending_after_ack", 8'd240, 8'h08);
        bus_write(8'd243, 8'h00);
        wait_req("t3_second");
        read_check("t3_active_3", 8'd242, 8'h83);
        ack();
        bus_write(8'd243, 8'h00);
        read_check("t3_pending_done", 8'd240, 8'h00);

        // 4: masked source becomes a request once enabled
        bus_write(8'd241, 8'h00);
        pulse(4'b0001);
        tick(3);
        check("t4_masked_no_req", {7'd0, int_req}, 8'h00);
        read_check("t4_pending", 8'd240, 8'h01);
        exp_q.push_back(8'h40);
        bus_write(8'd241, 8'h01);
        check("t4_req_not_yet", {7'd0, int_req}, 8'h00);
        tick(1);
        check("t4_req_one_later", {7'd0, int_req}, 8'h01);
        wait_req("t4");
        ack();
        bus_write(8'd243, 8'h00);

        // 5: level source 2
        bus_write(8'd246, 8'h22);
        bus_write(8'd241, 8'h04);
        exp_q.push_back(8'h22);
        irq_src[2] = 1'b1;
        wait_req("t5_first");
        bus_write(8'd240, 8'h04);
        read_check("t5_w1c_ignored", 8'd240, 8'h04);
        ack();
        exp_q.push_back(8'h22);
        bus_write(8'd243, 8'h00);
        check("t5_eoi_idle_req", {7'd0, int_req}, 8'h00);
        check("t5_eoi_idle_en",  {7'd0, int_en},  8'h01);
        tick(1);
        check("t5_rerequest", {7'd0, int_req}, 8'h01);
        wait_req("t5_second");
        ack();
        irq_src[2] = 1'b0;
        tick(2);
        bus_write(8'd243, 8'h00);
        tick(3);
        check("t5_no_third_req", {7'd0, int_req}, 8'h00);
        check("t5_idle_en", {7'd0, int_en}, 8'h01);
        read_check("t5_pending_clear", 8'd240, 8'h00);

        // 6: set/clear collision, EOI during REQ, VEC write during REQ
        bus_write(8'd241, 8'h00);
        irq_src[0] = 1'b1;
        addr       = 8'd240;
        w_data     = 8'h01;
        w_en       = 1'b1;
        @(negedge clock);
        w_en       = 1'b0;
        irq_src[0] = 1'b0;
        read_check("t6_collision_set_wins", 8'd240, 8'h01);
        bus_write(8'd240, 8'h01);
        read_check("t6_w1c_clears", 8'd240, 8'h00);
        pulse(4'b0001);
        read_check("t6_pending_again", 8'd240, 8'h01);
        exp_q.push_back(8'h40);
        bus_write(8'd241, 8'h01);
        tick(1);
        wait_req("t6");
        bus_write(8'd243, 8'h00);
        check("t6_eoi_in_req_ignored", {7'd0, int_req}, 8'h01);
        read_check("t6_active_still_req", 8'd242, 8'h80);
        bus_write(8'd244, 8'h99);
        check("t6_vec_latched", int_vec, 8'h40);
        read_check("t6_vec0_readback", 8'd244, 8'h99);
        ack();
        check("t6_ack_int_req", {7'd0, int_req}, 8'h00);
        read_check("t6_pending_acked", 8'd240, 8'h00);
        bus_write(8'd243, 8'h00);
        check("t6_eoi_int_en", {7'd0, int_en}, 8'h01);

        check("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
